// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional macro SIGNED_EN: treat bin_in as two's complement and report the sign on sign_out.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  sign_out,
    output logic                  state_dbg
);

    // Handshake: start is accepted only on an edge where busy=0 (IDLE); busy then stays
    // high for WIDTH cycles; done pulses for one cycle with bcd_out/overflow/sign_out valid.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]    sr;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [4*DIGITS-1:0] acc_shift;
    logic                ovf_acc;
    logic                sign_acc;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                last_shift;
    logic                top_out;
    logic [WIDTH-1:0]    load_val;
    logic                load_sign;

    // Operand conditioning at the accepted start edge
    always_comb begin
        load_val  = bin_in;
        load_sign = 1'b0;
`ifdef SIGNED_EN
        load_sign = bin_in[WIDTH-1];
        if (load_sign) begin
            load_val = ~bin_in + WIDTH'(1);
        end
`endif
    end

    // Per-digit add-3 correction, no carry between digits
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_shift  = {acc_adj[4*DIGITS-2:0], sr[WIDTH-1]};
    assign top_out    = acc_adj[4*DIGITS-1];
    assign accept     = (state == IDLE) && start;
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        state_dbg  = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            sign_acc <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            sign_out <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sr       <= load_val;
                acc      <= '0;
                ovf_acc  <= 1'b0;
                sign_acc <= load_sign;
                cnt      <= '0;
            end else if (state == SHIFT) begin
                sr      <= sr << 1;
                acc     <= acc_shift;
                ovf_acc <= ovf_acc | top_out;
                cnt     <= cnt + CNT_W'(1);
                // Results are taken from the post-shift values so the final bit is included
                if (last_shift) begin
                    bcd_out  <= acc_shift;
                    overflow <= ovf_acc | top_out;
                    sign_out <= sign_acc;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (8/3, 8/2 and 1/1 configurations).
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy, done, overflow, sign_out, state_dbg;
    logic [11:0] bcd_out;

    logic        start2;
    logic [7:0]  bin2;
    logic        busy2, done2, ovf2, sign2, dbg2;
    logic [7:0]  bcd2;

    logic        start1;
    logic [0:0]  bin1;
    logic        busy1, done1, ovf1, sign1, dbg1;
    logic [3:0]  bcd1;

    int n_checks;
    int n_fail;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy), .done(done),
        .bcd_out(bcd_out), .overflow(overflow), .sign_out(sign_out), .state_dbg(state_dbg)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin_in(bin2), .busy(busy2), .done(done2),
        .bcd_out(bcd2), .overflow(ovf2), .sign_out(sign2), .state_dbg(dbg2)
    );

    bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin_in(bin1), .busy(busy1), .done(done1),
        .bcd_out(bcd1), .overflow(ovf1), .sign_out(sign1), .state_dbg(dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m;
        m = int'(v);
`ifdef SIGNED_EN
        if (v[7]) m = 256 - int'(v);
`endif
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_sign(input logic [7:0] v);
`ifdef SIGNED_EN
        return v[7];
`else
        return 1'b0 & v[7];
`endif
    endfunction

    // driver: one conversion on dut, returns observed results at the done sample
    task automatic convert(input logic [7:0] v, output logic [11:0] r_bcd, output logic r_ovf,
                           output logic r_sign, output int n_busy, output bit got);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'($urandom_range(0, 255));
        n_busy = 0;
        got    = 1'b0;
        r_bcd  = '0;
        r_ovf  = 1'b0;
        r_sign = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got    = 1'b1;
                r_bcd  = bcd_out;
                r_ovf  = overflow;
                r_sign = sign_out;
                break;
            end
            if (busy) n_busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; start1 = 1'b0;
        bin_in = '0; bin2 = '0; bin1 = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, bcd_out, overflow, sign_out} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, bcd_out, overflow, sign_out});
        end
        n_checks++;
        if ({busy2, done2, bcd2, ovf2, busy1, done1, bcd1, ovf1} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_aux: got %h expected 0", {busy2, done2, bcd2, ovf2, busy1, done1, bcd1, ovf1});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: busy=%b done=%b expected 0 0 (cycle %0d)", busy, done, i);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0]  vals [4] = '{8'd255, 8'd0, 8'd100, 8'd99};
`ifdef SIGNED_EN
        logic [11:0] exps [4] = '{12'h001, 12'h000, 12'h100, 12'h099};
`else
        logic [11:0] exps [4] = '{12'h255, 12'h000, 12'h100, 12'h099};
`endif
        logic [11:0] r_bcd;
        logic r_ovf, r_sign;
        int nb;
        bit got;
        for (int k = 0; k < 4; k++) begin
            convert(vals[k], r_bcd, r_ovf, r_sign, nb, got);
            n_checks++;
            if (!got || nb != 8) begin
                n_fail++;
                $display("FAIL latency_%0d: done=%b busy_cycles=%0d expected 1 8", vals[k], got, nb);
            end
            n_checks++;
            if (r_bcd !== exps[k] || r_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d: got %h ovf %b expected %h ovf 0", vals[k], r_bcd, r_ovf, exps[k]);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || bcd_out !== exps[k]) begin
                n_fail++;
                $display("FAIL done_pulse_%0d: done=%b bcd=%h expected 0 %h", vals[k], done, bcd_out, exps[k]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [11:0] r_bcd;
        logic r_ovf, r_sign;
        int nb;
        bit got;
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), r_bcd, r_ovf, r_sign, nb, got);
            n_checks++;
            if (!got || r_bcd !== ref_bcd(8'(v)) || r_ovf !== 1'b0 || r_sign !== ref_sign(8'(v))) begin
                n_fail++;
                $display("FAIL sweep_%0d: done=%b got %h ovf %b sign %b expected %h ovf 0 sign %b",
                         v, got, r_bcd, r_ovf, r_sign, ref_bcd(8'(v)), ref_sign(8'(v)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int last_t, n_done;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd42;
        last_t = -1;
        n_done = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done) begin
                n_checks++;
                if (bcd_out !== 12'h042) begin
                    n_fail++;
                    $display("FAIL b2b_value: got %h expected 042", bcd_out);
                end
                if (last_t >= 0) begin
                    n_checks++;
                    if (t - last_t != 9) begin
                        n_fail++;
                        $display("FAIL b2b_interval: got %0d expected 9", t - last_t);
                    end
                end
                last_t = t;
                n_done++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_done < 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected >= 6", n_done);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_abort();
        int n_done;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, bcd_out, overflow, sign_out} !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_clear: got %h expected 0", {busy, done, bcd_out, overflow, sign_out});
        end
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        n_checks++;
        if (n_done != 0 || bcd_out !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_no_done: activity=%0d bcd=%h expected 0 000", n_done, bcd_out);
        end
    endtask

    task automatic test_ignored_start();
        bit got;
        int n_busy;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd37;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd99;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!got || bcd_out !== 12'h037) begin
            n_fail++;
            $display("FAIL ignored_start: done=%b got %h expected 037", got, bcd_out);
        end
        n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
        end
        n_checks++;
        if (n_busy != 0) begin
            n_fail++;
            $display("FAIL not_queued: busy_cycles=%0d expected 0", n_busy);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [3] = '{8'd123, 8'd99, 8'd100};
        logic [7:0] exps [3] = '{8'h23, 8'h99, 8'h00};
        logic       eovf [3] = '{1'b1, 1'b0, 1'b1};
        bit got;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start2 = 1'b1;
            bin2   = vals[k];
            @(negedge clk);
            start2 = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (done2) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            n_checks++;
            if (!got || bcd2 !== exps[k] || ovf2 !== eovf[k]) begin
                n_fail++;
                $display("FAIL overflow_%0d: done=%b got %h ovf %b expected %h ovf %b",
                         vals[k], got, bcd2, ovf2, exps[k], eovf[k]);
            end
        end
    endtask

    task automatic test_width1();
        logic [3:0] exps [2] = '{4'h0, 4'h1};
        bit got;
        int nb;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start1 = 1'b1;
            bin1   = 1'(k);
            @(negedge clk);
            start1 = 1'b0;
            got = 1'b0;
            nb  = 0;
            for (int i = 0; i < 10; i++) begin
                if (done1) begin
                    got = 1'b1;
                    break;
                end
                if (busy1) nb++;
                @(negedge clk);
            end
            n_checks++;
            if (!got || nb != 1 || bcd1 !== exps[k] || ovf1 !== 1'b0) begin
                n_fail++;
                $display("FAIL width1_%0d: done=%b busy=%0d got %h ovf %b expected 1 1 %h 0",
                         k, got, nb, bcd1, ovf1, exps[k]);
            end
        end
    endtask

    task automatic test_signed();
`ifdef SIGNED_EN
        logic [7:0]  vals [3] = '{8'hFF, 8'h80, 8'h7F};
        logic [11:0] exps [3] = '{12'h001, 12'h128, 12'h127};
        logic        sgns [3] = '{1'b1, 1'b1, 1'b0};
`else
        logic [7:0]  vals [3] = '{8'hFF, 8'h80, 8'h7F};
        logic [11:0] exps [3] = '{12'h255, 12'h128, 12'h127};
        logic        sgns [3] = '{1'b0, 1'b0, 1'b0};
`endif
        logic [11:0] r_bcd;
        logic r_ovf, r_sign;
        int nb;
        bit got;
        for (int k = 0; k < 3; k++) begin
            convert(vals[k], r_bcd, r_ovf, r_sign, nb, got);
            n_checks++;
            if (!got || nb != 8 || r_bcd !== exps[k] || r_sign !== sgns[k]) begin
                n_fail++;
                $display("FAIL signed_%h: done=%b busy=%0d got %h sign %b expected 1 8 %h sign %b",
                         vals[k], got, nb, r_bcd, r_sign, exps[k], sgns[k]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_abort();
        test_ignored_start();
        test_overflow();
        test_width1();
        test_signed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
